// File: rtl/output_arbiter_if.sv
// output_arbiter_if: request/flit bus from two input controllers into one output port
interface output_arbiter_if #(
  parameter int DATA_W = 11,
  parameter int CNT_W  = 16
);
  logic              req_0;
  logic              req_1;
  logic [DATA_W-1:0] data_0;
  logic [DATA_W-1:0] data_1;
  logic              out_full;
  logic              ready_0;
  logic              ready_1;
  logic              out_wr;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  pkt_count;
  modport master (
    output req_0, req_1, data_0, data_1, out_full,
    input  ready_0, ready_1, out_wr, out_data, pkt_count
  );
  modport slave (
    input  req_0, req_1, data_0, data_1, out_full,
    output ready_0, ready_1, out_wr, out_data, pkt_count
  );
endinterface

// File: rtl/output_arbiter.sv
// output_arbiter: round-robin wormhole arbiter of two inputs onto one output FIFO
module output_arbiter #(
  parameter int DATA_W = 11,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               reset,
  output_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, GRANT_0, GRANT_1} state_t;
  state_t state, next;
  logic   last_grant;
  logic   tail;
  always_comb begin
    next         = state;
    bus.ready_0  = 1'b0;
    bus.ready_1  = 1'b0;
    bus.out_wr   = 1'b0;
    bus.out_data = '0;
    case (state)
      IDLE: next = (bus.req_0 && bus.req_1) ? (last_grant ? GRANT_0 : GRANT_1) :
                   bus.req_0 ? GRANT_0 : bus.req_1 ? GRANT_1 : IDLE;
      GRANT_0: begin
        bus.ready_0  = ~bus.out_full;
        bus.out_wr   = bus.req_0 & ~bus.out_full;
        bus.out_data = bus.data_0;
      end
      GRANT_1: begin
        bus.ready_1  = ~bus.out_full;
        bus.out_wr   = bus.req_1 & ~bus.out_full;
        bus.out_data = bus.data_1;
      end
      default: next = IDLE;
    endcase
    tail = bus.out_wr & bus.out_data[DATA_W-1];
    if (tail) next = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      bus.pkt_count <= '0;
    end else begin
      state <= next;
      if (tail) begin
        last_grant    <= (state == GRANT_1);
        bus.pkt_count <= bus.pkt_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: vector table, directed corner sequences and randomized model checks
module tb_output_arbiter;
  localparam int DW = 11;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  output_arbiter_if #(.DATA_W(DW), .CNT_W(CW)) a ();
  output_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(a));
  int checks = 0;
  int errors = 0;
  int m_owner = -1;
  int m_last = 1;
  int m_count = 0;
  logic [DW-1:0] wq[$];
  always @(negedge clk) if (a.out_wr === 1'b1) wq.push_back(a.out_data);
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  task automatic drive(input bit r0, input bit r1, input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit f);
    a.req_0 = r0;
    a.req_1 = r1;
    a.data_0 = d0;
    a.data_1 = d1;
    a.out_full = f;
  endtask
  // one cycle against the packet-owner model; entered and left 1 time unit after a rising edge
  task automatic step(input bit r0, input bit r1, input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit f);
    bit wr;
    logic [DW-1:0] d;
    drive(r0, r1, d0, d1, f);
    @(negedge clk);
    wr = 1'b0;
    d = '0;
    if (m_owner == 0) begin wr = r0 & ~f; d = d0; end
    else if (m_owner == 1) begin wr = r1 & ~f; d = d1; end
    chk("ready_0", {31'd0, a.ready_0}, {31'd0, m_owner == 0 && !f});
    chk("ready_1", {31'd0, a.ready_1}, {31'd0, m_owner == 1 && !f});
    chk("out_wr", {31'd0, a.out_wr}, {31'd0, wr});
    chk("out_data", {21'd0, a.out_data}, {21'd0, d});
    chk("pkt_count", {24'd0, a.pkt_count}, m_count % (1 << CW));
    if (m_owner < 0) m_owner = (r0 && r1) ? 1 - m_last : r0 ? 0 : r1 ? 1 : -1;
    else if (wr && d[DW-1]) begin
      m_last = m_owner;
      m_owner = -1;
      m_count++;
    end
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    bit r0; bit r1; logic [DW-1:0] d0; logic [DW-1:0] d1; bit f;
    bit e0; bit e1; bit ew; logic [DW-1:0] ed; int ec;
  } vec_t;
  vec_t tv[11];
  logic [DW-1:0] fl[3];
  int start;
  initial begin
    tv[0]  = '{1, 1, 11'h400, 11'h401, 0, 0, 0, 0, 11'h000, 0};
    tv[1]  = '{1, 1, 11'h400, 11'h401, 0, 1, 0, 1, 11'h400, 0};
    tv[2]  = '{1, 1, 11'h400, 11'h401, 0, 0, 0, 0, 11'h000, 1};
    tv[3]  = '{1, 1, 11'h400, 11'h401, 0, 0, 1, 1, 11'h401, 1};
    tv[4]  = '{1, 1, 11'h005, 11'h402, 0, 0, 0, 0, 11'h000, 2};
    tv[5]  = '{1, 1, 11'h005, 11'h402, 0, 1, 0, 1, 11'h005, 2};
    tv[6]  = '{1, 1, 11'h006, 11'h402, 0, 1, 0, 1, 11'h006, 2};
    tv[7]  = '{1, 1, 11'h407, 11'h402, 0, 1, 0, 1, 11'h407, 2};
    tv[8]  = '{1, 1, 11'h407, 11'h402, 0, 0, 0, 0, 11'h000, 3};
    tv[9]  = '{1, 1, 11'h407, 11'h402, 0, 0, 1, 1, 11'h402, 3};
    tv[10] = '{0, 0, 11'h000, 11'h000, 0, 0, 0, 0, 11'h000, 4};
    drive(1, 1, 11'h7ff, 11'h7ff, 0);
    #1;
    chk("rst_ready_0", {31'd0, a.ready_0}, 0);
    chk("rst_ready_1", {31'd0, a.ready_1}, 0);
    chk("rst_out_wr", {31'd0, a.out_wr}, 0);
    chk("rst_out_data", {21'd0, a.out_data}, 0);
    chk("rst_pkt_count", {24'd0, a.pkt_count}, 0);
    drive(0, 0, 0, 0, 0);
    #11 reset = 1'b0;
    @(posedge clk);
    #1;
    // tie after reset, then wormhole hold with req_1 pending
    for (int i = 0; i < 11; i++) begin
      drive(tv[i].r0, tv[i].r1, tv[i].d0, tv[i].d1, tv[i].f);
      @(negedge clk);
      chk($sformatf("tv%0d_ready_0", i), {31'd0, a.ready_0}, {31'd0, tv[i].e0});
      chk($sformatf("tv%0d_ready_1", i), {31'd0, a.ready_1}, {31'd0, tv[i].e1});
      chk($sformatf("tv%0d_out_wr", i), {31'd0, a.out_wr}, {31'd0, tv[i].ew});
      chk($sformatf("tv%0d_out_data", i), {21'd0, a.out_data}, {21'd0, tv[i].ed});
      chk($sformatf("tv%0d_pkt_count", i), {24'd0, a.pkt_count}, tv[i].ec);
      @(posedge clk);
      #1;
    end
    m_owner = -1; m_last = 1; m_count = 4;
    // backpressure: out_full for 4 cycles mid-packet
    fl[0] = 11'h011; fl[1] = 11'h012; fl[2] = 11'h413;
    wq.delete();
    for (int c = 0; c < 20 && wq.size() < 3; c++)
      step(1, 1, fl[wq.size()], 11'h000, c >= 3 && c < 7);
    chk("bp_flits", wq.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("bp_flit%0d", i), {21'd0, wq[i]}, {21'd0, fl[i]});
    step(0, 0, 0, 0, 0);
    // request gap: req_0 low for 2 cycles mid-packet while req_1 waits
    fl[0] = 11'h021; fl[1] = 11'h022; fl[2] = 11'h423;
    wq.delete();
    for (int c = 0; c < 20 && wq.size() < 3; c++)
      step(!(c == 2 || c == 3), c > 0, fl[wq.size()], 11'h4aa, 0);
    chk("gap_flits", wq.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("gap_flit%0d", i), {21'd0, wq[i]}, {21'd0, fl[i]});
    step(0, 0, 0, 0, 0);
    // reset mid-packet after flit 1 of 3
    step(1, 0, 11'h031, 0, 0);
    step(1, 0, 11'h031, 0, 0);
    drive(1, 0, 11'h032, 0, 0);
    reset = 1'b1;
    #1;
    chk("midrst_ready_0", {31'd0, a.ready_0}, 0);
    chk("midrst_out_wr", {31'd0, a.out_wr}, 0);
    chk("midrst_out_data", {21'd0, a.out_data}, 0);
    chk("midrst_pkt_count", {24'd0, a.pkt_count}, 0);
    m_owner = -1; m_last = 1; m_count = 0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1, 0, 11'h403, 0);
    step(0, 1, 0, 11'h403, 0);
    chk("midrst_after_count", {24'd0, a.pkt_count}, 1);
    // counter wrap: 2^CW single-flit packets
    start = m_count;
    for (int i = 0; i < 2 * (1 << CW); i++) step(1, 0, 11'h400, 0, 0);
    chk("wrap_count", {24'd0, a.pkt_count}, start % (1 << CW));
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           {($urandom_range(0, 3) == 0), 10'($urandom)},
           {($urandom_range(0, 3) == 0), 10'($urandom)},
           $urandom_range(0, 3) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
